accum_drain_reader: RTL and testbench

- Read-side engine for the write-back bank of the accumulation buffer.
- On `start`, it reads `num_words` consecutive entries from address 0 through the 1-cycle-latency `ren_wb`/`radr_wb`/`rdata_wb` port.
- It streams those words off-chip on a valid/ready interface, with full throughput and lossless backpressure.
- It reports `busy`/`done` to the top-level controller, which gates `switch_banks`.

---
 rtl/accum_drain_reader_pkg.sv | 8 +
 rtl/accum_drain_reader_sync_fifo2.sv | 35 +++
 rtl/accum_drain_reader.sv | 90 +++++++++
 tb/tb_accum_drain_reader.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/accum_drain_reader_pkg.sv
// accum_drain_reader_pkg: shared FIFO depth, drain state type and count-width helper
package accum_drain_reader_pkg;
  localparam int DRAIN_FIFO_DEPTH = 2;
  typedef enum logic {IDLE, DRAIN} state_t;
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/accum_drain_reader_sync_fifo2.sv
// sync_fifo2: 2-entry register FIFO whose head register drives dout directly
// ports: clk, rst, flush (sync clear), push/din, pop, dout (head), cnt, full, empty
module sync_fifo2
  import accum_drain_reader_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   cnt,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [DRAIN_FIFO_DEPTH];
  logic do_pop;
  logic [1:0] base;
  assign full = cnt == 2'(DRAIN_FIFO_DEPTH);
  assign empty = cnt == 2'd0;
  assign dout = mem[0];
  assign do_pop = pop && !empty;
  // occupancy after the pop; the pushed word lands in that slot
  assign base = cnt - 2'(do_pop);
  always_ff @(posedge clk) begin
    if (rst || flush) cnt <= '0;
    else cnt <= base + 2'(push);
    if (do_pop) mem[0] <= mem[1];
    if (push) mem[base[0]] <= din;
    if (!rst && !flush) assert (!(push && base == 2'd2));
  end
endmodule

// File: rtl/accum_drain_reader.sv
// accum_drain_reader: drains num_words from the write-back bank onto a valid/ready stream
// ports: clk, rst, start/num_words (launch), switch_banks (abort), ren_wb/radr_wb/rdata_wb
// (1-cycle read port), out_valid/out_data/out_ready (stream), busy, done, abort_err
module accum_drain_reader
  import accum_drain_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BANK_ADDR_WIDTH = 7,
  parameter int BANK_DEPTH = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [BANK_ADDR_WIDTH:0]   num_words,
  input  logic                       switch_banks,
  output logic                       ren_wb,
  output logic [BANK_ADDR_WIDTH-1:0] radr_wb,
  input  logic [DATA_WIDTH-1:0]      rdata_wb,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       abort_err
);
  localparam int CW = cnt_width(BANK_DEPTH);
  state_t state, state_n;
  logic [CW-1:0] total, rd_cnt, out_cnt, clamp;
  logic inflight, pop, abort, last, accept, zero_start;
  logic [1:0] fifo_cnt;
  logic fifo_full, fifo_empty;
  assign pop = out_valid && out_ready;
  assign abort = state == DRAIN && switch_banks;
  assign last = pop && out_cnt + CW'(1) == total;
  // a start coinciding with the done pulse is dropped
  assign accept = state == IDLE && start && !done && num_words != '0;
  assign zero_start = state == IDLE && start && !done && num_words == '0;
  assign clamp = num_words > CW'(BANK_DEPTH) ? CW'(BANK_DEPTH) : CW'(num_words);
  assign out_valid = !fifo_empty;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == IDLE ? (accept ? DRAIN : IDLE) : (abort || last ? IDLE : DRAIN);
  end
  // credit: buffered + in-flight words after this cycle's pop must stay below 2
  always_comb begin
    busy = state == DRAIN;
    radr_wb = rd_cnt[BANK_ADDR_WIDTH-1:0];
    ren_wb = state == DRAIN && rd_cnt < total &&
             ({1'b0, fifo_cnt} + 3'(inflight) - 3'(pop)) < 3'd2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      total <= '0;
      rd_cnt <= '0;
      out_cnt <= '0;
      inflight <= 1'b0;
      done <= 1'b0;
      abort_err <= 1'b0;
    end else begin
      done <= zero_start || (state == DRAIN && !switch_banks && last);
      inflight <= ren_wb && !abort;
      if (accept) begin
        total <= clamp;
        rd_cnt <= '0;
        out_cnt <= '0;
        abort_err <= 1'b0;
      end else begin
        if (ren_wb) rd_cnt <= rd_cnt + CW'(1);
        if (pop) out_cnt <= out_cnt + CW'(1);
        if (abort) abort_err <= 1'b1;
      end
      assert (!(inflight && fifo_full && !pop));
    end
  end
  sync_fifo2 #(.W(DATA_WIDTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(abort),
    .push(inflight),
    .pop(pop),
    .din(rdata_wb),
    .dout(out_data),
    .cnt(fifo_cnt),
    .full(fifo_full),
    .empty(fifo_empty)
  );
endmodule

// File: tb/tb_accum_drain_reader.sv
// tb_accum_drain_reader: randomized self-checking bench with a queue-based reference model
module tb_accum_drain_reader;
  localparam int DW = 64, AW = 7, DEPTH = 128;
  logic clk = 0, rst = 1, start = 0, switch_banks = 0, out_ready = 1;
  logic [AW:0] num_words = '0;
  logic ren_wb, out_valid, busy, done, abort_err;
  logic [AW-1:0] radr_wb;
  logic [DW-1:0] rdata_wb, out_data;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] prev_data;
  logic [5:0] pat = 6'b101001;
  int checks = 0, errors = 0;
  int exp_total, reads, outs, dones, mode, k;
  bit mon_en = 0, prev_stall = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (ren_wb) rdata_wb <= mem[radr_wb];

  accum_drain_reader dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words), .switch_banks(switch_banks),
    .ren_wb(ren_wb), .radr_wb(radr_wb), .rdata_wb(rdata_wb), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .busy(busy), .done(done), .abort_err(abort_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    if (ren_wb) begin
      if (reads >= exp_total) chk("extra_read", 64'(reads + 1), 64'(exp_total));
      else chk("radr", 64'(radr_wb), 64'(reads % DEPTH));
      reads++;
    end
    if (out_valid && prev_stall) chk("stall_hold", out_data, prev_data);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_word", 64'(outs + 1), 64'(exp_total));
      else chk("data", out_data, exp_q.pop_front());
      outs++;
    end
    prev_stall = out_valid && !out_ready;
    prev_data = out_data;
    if (done) dones++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    out_ready = mode == 0 ? 1'b1 : mode == 1 ? pat[k % 6] : 1'($urandom_range(0, 1));
    @(negedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
  endtask

  task automatic begin_drain(input int n);
    exp_total = n > DEPTH ? DEPTH : n;
    exp_q.delete();
    for (int i = 0; i < exp_total; i++) exp_q.push_back(mem[i]);
    reads = 0;
    outs = 0;
    dones = 0;
    start = 1;
    num_words = (AW + 1)'(n);
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (dones == 0 && c < budget) begin
      tick();
      c++;
    end
    chk("done_seen", 64'(dones), 64'd1);
  endtask

  task automatic finish_chk();
    repeat (3) tick();
    chk("done_once", 64'(dones), 64'd1);
    chk("reads", 64'(reads), 64'(exp_total));
    chk("outs", 64'(outs), 64'(exp_total));
    chk("idle", 64'(busy), 64'd0);
  endtask

  initial begin
    mode = 0;
    k = 0;
    repeat (2) tick();
    chk("rst_ren", 64'(ren_wb), 0);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_abort", 64'(abort_err), 0);
    chk("rst_radr", 64'(radr_wb), 0);
    rst = 0;
    tick();
    mon_en = 1;
    // full throughput, exact cycle timing
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 3);
    begin_drain(8);
    for (int c = 1; c <= 12; c++) begin
      chk($sformatf("t_ren%0d", c), 64'(ren_wb), 64'(c <= 8));
      chk($sformatf("t_valid%0d", c), 64'(out_valid), 64'(c >= 3 && c <= 10));
      chk($sformatf("t_done%0d", c), 64'(done), 64'(c == 11));
      tick();
    end
    finish_chk();
    // backpressure pattern
    fill_random();
    mode = 1;
    begin_drain(5);
    wait_done(100);
    finish_chk();
    // zero words
    mode = 0;
    begin_drain(0);
    chk("zero_done", 64'(done), 1);
    chk("zero_busy", 64'(busy), 0);
    tick();
    chk("zero_done_clr", 64'(done), 0);
    finish_chk();
    // clamp to full depth
    fill_random();
    begin_drain(200);
    wait_done(400);
    finish_chk();
    // abort mid-drain
    begin_drain(10);
    for (int c = 0; c < 50 && outs < 3; c++) tick();
    switch_banks = 1;
    tick();
    switch_banks = 0;
    chk("ab_valid", 64'(out_valid), 0);
    chk("ab_err", 64'(abort_err), 1);
    chk("ab_busy", 64'(busy), 0);
    repeat (5) tick();
    chk("ab_nodone", 64'(dones), 0);
    chk("ab_sticky", 64'(abort_err), 1);
    begin_drain(2);
    chk("ab_clr", 64'(abort_err), 0);
    wait_done(50);
    finish_chk();
    // reset mid-drain, start held during reset
    begin_drain(16);
    repeat (4) tick();
    mon_en = 0;
    rst = 1;
    start = 1;
    num_words = 3;
    tick();
    chk("mr_ren", 64'(ren_wb), 0);
    chk("mr_valid", 64'(out_valid), 0);
    chk("mr_busy", 64'(busy), 0);
    chk("mr_done", 64'(done), 0);
    chk("mr_radr", 64'(radr_wb), 0);
    tick();
    rst = 0;
    start = 0;
    tick();
    chk("mr_idle", 64'(busy), 0);
    chk("mr_noread", 64'(ren_wb), 0);
    prev_stall = 0;
    mon_en = 1;
    // start while busy, then start coinciding with done
    fill_random();
    mode = 2;
    begin_drain(6);
    repeat (2) tick();
    start = 1;
    num_words = 3;
    tick();
    start = 0;
    wait_done(100);
    start = 1;
    num_words = 2;
    tick();
    start = 0;
    chk("sd_ignored", 64'(busy), 0);
    finish_chk();
    // random drains
    for (int it = 0; it < 8; it++) begin
      fill_random();
      begin_drain(int'($urandom_range(1, 40)));
      wait_done(300);
      finish_chk();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
